// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: four-requester round-robin arbiter with a registered one-hot grant,
// an encoded index and an optional hold timeout.  Rev 1.0
`default_nettype none

module rr_grant_encoder #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout_err
);

  localparam int CNT_W       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LAST_I = (MAX_HOLD < 1) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LAST_I);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_err_q, timeout_err_d;

  logic [1:0] sel;
  logic       sel_found;
  logic       owner_req;
  logic       hold_expired;
  logic       release_w;

  // First requester at or after the priority pointer, wrapping mod 4.
  always_comb begin
    sel       = 2'd0;
    sel_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!sel_found && req[ptr_q + 2'(k)]) begin
        sel       = ptr_q + 2'(k);
        sel_found = 1'b1;
      end
    end
  end

  assign owner_req    = req[gnt_idx_q];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign release_w    = done || !owner_req || hold_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= 2'd0;
      hold_cnt_q    <= '0;
      gnt_q         <= 4'b0000;
      gnt_idx_q     <= 2'd0;
      gnt_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      gnt_q         <= gnt_d;
      gnt_idx_q     <= gnt_idx_d;
      gnt_valid_q   <= gnt_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel_found) state_d = S_GRANT;
      S_GRANT: if (release_w) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    gnt_d         = gnt_q;
    gnt_idx_d     = gnt_idx_q;
    gnt_valid_d   = gnt_valid_q;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gnt_d       = 4'b0001 << sel;
          gnt_idx_d   = sel;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      S_GRANT: begin
        if (release_w) begin
          gnt_d         = 4'b0000;
          gnt_valid_d   = 1'b0;
          ptr_d         = gnt_idx_q + 2'd1;
          // Only a pure timeout is an error; done or a dropped request wins.
          timeout_err_d = hold_expired && !done && owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d       = 4'b0000;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = gnt_idx_q;
  assign gnt_valid   = gnt_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: drives two arbiter instances (MAX_HOLD 16 and 4) against a cycle-level reference model.
// Rev 1.0
`default_nettype none

module tb_rr_grant_encoder;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;

  logic [3:0] g0, g1;
  logic [1:0] i0, i1;
  logic       v0, v1, t0, t1;

  int n_cmp = 0;
  int n_err = 0;

  rr_grant_encoder dut0 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(g0), .gnt_idx(i0), .gnt_valid(v0), .timeout_err(t0)
  );

  rr_grant_encoder #(.MAX_HOLD(4)) dut1 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(g1), .gnt_idx(i1), .gnt_valid(v1), .timeout_err(t1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] obs [2];
  assign obs[0] = {g0, i0, v0, t0};
  assign obs[1] = {g1, i1, v1, t1};

  // Reference model: grant owner, pointer and elapsed hold per instance.
  int m_busy [2];
  int m_own  [2];
  int m_ptr  [2];
  int m_cnt  [2];
  int m_idx  [2];
  int m_to   [2];

  function automatic int mh(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_own[i] = 0; m_ptr[i] = 0;
      m_cnt[i]  = 0; m_idx[i] = 0; m_to[i]  = 0;
    end
  endtask

  task automatic model_edge(input int i);
    int c;
    bit rd, rq, rt;
    if (m_busy[i] == 0) begin
      m_to[i] = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr[i] + k) % 4;
        if (req[c] && m_busy[i] == 0) begin
          m_busy[i] = 1; m_own[i] = c; m_idx[i] = c; m_cnt[i] = 0;
        end
      end
    end else begin
      rd = done;
      rq = !req[m_own[i]];
      rt = (mh(i) != 0) && (m_cnt[i] == mh(i) - 1);
      if (rd || rq || rt) begin
        m_busy[i] = 0;
        m_ptr[i]  = (m_own[i] + 1) % 4;
        m_to[i]   = (rt && !rd && !rq) ? 1 : 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
        m_to[i]  = 0;
      end
    end
  endtask

  function automatic logic [7:0] exp_vec(input int i);
    logic [3:0] eg;
    eg = (m_busy[i] != 0) ? 4'(1 << m_own[i]) : 4'b0000;
    return {eg, 2'(m_idx[i]), 1'(m_busy[i] != 0), 1'(m_to[i] != 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!reset) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Structural invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (!$onehot0(g0) || v0 !== (|g0) || (v0 && g0 !== (4'b0001 << i0)) || (t0 && v0) ||
          !$onehot0(g1) || v1 !== (|g1) || (v1 && g1 !== (4'b0001 << i1)) || (t1 && v1)) begin
        n_err++;
        $display("FAIL invariant: dut0 gnt=%b idx=%0d v=%b to=%b dut1 gnt=%b idx=%0d v=%b to=%b",
                 g0, i0, v0, t0, g1, i1, v1, t1);
      end
    end
  end

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (obs[0] !== 8'h00 || obs[1] !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got %b / %b, want 00000000", obs[0], obs[1]);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    step();
    n_cmp++;
    if (g0 !== 4'b0100 || i0 !== 2'd2 || v0 !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: gnt=%b idx=%0d, want 0100 idx 2", g0, i0);
    end
    step(); step(); step();
    done = 1'b1;
    step();
    done = 1'b0;
    n_cmp++;
    if (g0 !== 4'b0000 || i0 !== 2'd2 || t0 !== 1'b0) begin
      n_err++;
      $display("FAIL single_release: gnt=%b idx=%0d to=%b, want 0000 idx 2 to 0", g0, i0, t0);
    end
    step();
    n_cmp++;
    if (g0 !== 4'b0100) begin
      n_err++;
      $display("FAIL single_regrant: gnt=%b, want 0100", g0);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b1111;
    step();
    n_cmp++;
    if (g0 !== 4'b1000 || i0 !== 2'd3) begin
      n_err++;
      $display("FAIL single_ptr: gnt=%b idx=%0d, want 1000 idx 3", g0, i0);
    end
  endtask

  task automatic test_fair();
    logic [3:0] want;
    apply_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      want = 4'b0001 << (g % 4);
      step();
      step();
      n_cmp++;
      if (g0 !== want || i0 !== 2'(g % 4) || g1 !== want) begin
        n_err++;
        $display("FAIL fair_grant[%0d]: gnt=%b/%b idx=%0d, want %b", g, g0, g1, i0, want);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      n_cmp++;
      if (g0 !== 4'b0000 || g1 !== 4'b0000 || i0 !== 2'(g % 4)) begin
        n_err++;
        $display("FAIL fair_gap[%0d]: gnt=%b/%b idx=%0d, want 0000", g, g0, g1, i0);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (g1 !== 4'b0010 || t1 !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_hold[%0d]: gnt=%b to=%b, want 0010 to 0", c, g1, t1);
      end
    end
    step();
    n_cmp++;
    if (g1 !== 4'b0000 || t1 !== 1'b1 || g0 !== 4'b0010 || t0 !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_fire: dut1 gnt=%b to=%b dut0 gnt=%b to=%b, want 0000/1 and 0010/0",
               g1, t1, g0, t0);
    end
    step();
    n_cmp++;
    if (g1 !== 4'b0010 || t1 !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_regrant: gnt=%b to=%b, want 0010 to 0", g1, t1);
    end
  endtask

  task automatic test_drop();
    apply_reset();
    req = 4'b0010;
    step();
    req = 4'b1010;
    step();
    req = 4'b1000;
    step();
    n_cmp++;
    if (g0 !== 4'b0000 || t0 !== 1'b0 || g1 !== 4'b0000 || t1 !== 1'b0) begin
      n_err++;
      $display("FAIL drop_release: gnt=%b/%b to=%b/%b, want 0000 to 0", g0, g1, t0, t1);
    end
    step();
    n_cmp++;
    if (g0 !== 4'b1000 || i0 !== 2'd3 || g1 !== 4'b1000) begin
      n_err++;
      $display("FAIL drop_next: gnt=%b/%b idx=%0d, want 1000 idx 3", g0, g1, i0);
    end
  endtask

  task automatic test_done_timeout();
    apply_reset();
    req = 4'b0010;
    step(); step(); step(); step();
    done = 1'b1;
    step();
    done = 1'b0;
    n_cmp++;
    if (g1 !== 4'b0000 || t1 !== 1'b0) begin
      n_err++;
      $display("FAIL done_timeout: gnt=%b to=%b, want 0000 to 0", g1, t1);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b1001;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    n_cmp++;
    if (g0 !== 4'b1000 || i0 !== 2'd3) begin
      n_err++;
      $display("FAIL rmid_pre: gnt=%b idx=%0d, want 1000 idx 3", g0, i0);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (g0 !== 4'b0000 || v0 !== 1'b0 || i0 !== 2'd0 || g1 !== 4'b0000 || i1 !== 2'd0) begin
      n_err++;
      $display("FAIL rmid_async: gnt=%b/%b v=%b idx=%0d/%0d, want all 0", g0, g1, v0, i0, i1);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_cmp++;
    if (g0 !== 4'b0001 || i0 !== 2'd0 || g1 !== 4'b0001) begin
      n_err++;
      $display("FAIL rmid_ptr: gnt=%b/%b idx=%0d, want 0001 idx 0", g0, g1, i0);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 4) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 9) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs[i] !== exp_vec(i)) begin
          n_err++;
          $display("FAIL random[%0d] inst%0d: got %b want %b (gnt,idx,valid,to)",
                   c, i, obs[i], exp_vec(i));
        end
      end
    end
    done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_fair();
    test_timeout();
    test_drop();
    test_done_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
